// File: rtl/mfcc_pkg.sv
// mfcc_pkg
// Constants and state encoding shared by the MFCC feature-memory readers
// and writers.
//   ADDR_WIDTH_14   : feature memory address width, {frame[6:0], col[6:0]}
//   DATA_WIDTH      : feature word width (IEEE-754 single)
//   FEAT_GROUPS     : static, delta, delta-2nd
//   EDGE_FRAMES_DEF : frames dropped at each utterance end (delta-2nd undefined)
package mfcc_pkg;

    localparam int ADDR_WIDTH_14   = 14;
    localparam int DATA_WIDTH      = 32;
    localparam int FEAT_GROUPS     = 3;
    localparam int EDGE_FRAMES_DEF = 4;
    localparam int FRAME_WIDTH     = 7;
    localparam int COL_WIDTH       = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/feature_skid_fifo.sv
// feature_skid_fifo
// Two-entry FIFO used as the output buffer of a valid/ready stream.
// A push and a pop in the same cycle are accepted even when full, because
// the pop frees the slot the push writes into.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (dropped only if full and not popping)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : current head entry
//   full/empty : occupancy flags
module feature_skid_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == 2'd2);
    assign empty    = (count_reg == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_reg[rd_ptr_reg];

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_reg[gi] <= '0;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/feature_stream_reader.sv
// feature_stream_reader
// Drains the finished MFCC feature memory as a valid/ready word stream.
// Frames EDGE_FRAMES .. frame_num-1-EDGE_FRAMES are read in frame-major
// order; per frame the static, delta and delta-2nd groups of cep_num
// words each are emitted, group g occupying columns g*(cep_num+1)+c.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, begin readout (ignored unless idle)
//   frame_num       : frames in the utterance
//   cep_num         : coefficients per group (1..41)
//   mem_rd_en/addr  : feature memory read port, data returns next cycle
//   mem_rd_data     : read data
//   out_data/valid  : stream word, held until out_ready
//   out_ready       : sink acceptance
//   out_last_vec    : last word of a frame vector
//   out_last_frame  : last word of the stream
//   busy            : readout in progress
//   done            : one-cycle completion pulse
module feature_stream_reader
    import mfcc_pkg::*;
#(
    parameter int EDGE_FRAMES = EDGE_FRAMES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [6:0]               frame_num,
    input  logic [6:0]               cep_num,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH_14-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last_vec,
    output logic                     out_last_frame,
    output logic                     busy,
    output logic                     done
);

    localparam logic [6:0] EDGE_7     = 7'(EDGE_FRAMES);
    localparam logic [6:0] MIN_FRAMES = 7'(2 * EDGE_FRAMES + 1);
    localparam logic [1:0] LAST_GROUP = 2'(FEAT_GROUPS - 1);

    rd_state_t              state_reg;
    logic [FRAME_WIDTH-1:0] frame_reg;
    logic [FRAME_WIDTH-1:0] last_frame_reg;
    logic [COL_WIDTH-1:0]   col_reg;
    logic [6:0]             c_reg;
    logic [1:0]             g_reg;
    logic [6:0]             cep_reg;
    logic                   inflight_reg;
    logic                   inflight_vec_reg;
    logic                   inflight_frm_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH+1:0]  fifo_head;
    logic                   pop;
    logic [1:0]             occ;
    logic [1:0]             occ_after;
    logic                   rd_en;
    logic                   last_c;
    logic                   last_g;
    logic                   last_f;
    logic                   empty_range;

    assign last_c      = (c_reg == cep_reg - 7'd1);
    assign last_g      = (g_reg == LAST_GROUP);
    assign last_f      = (frame_reg == last_frame_reg);
    assign empty_range = (frame_num < MIN_FRAMES) || (cep_num == 7'd0);

    // Occupancy counted after this cycle's pop, so a word leaving the FIFO
    // makes room for a new read in the same cycle: this is what sustains
    // one word per cycle with out_ready held high. The FIFO plus the single
    // read in flight can never exceed its two entries.
    assign pop       = out_valid && out_ready;
    assign occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occ_after = occ - {1'b0, pop} + {1'b0, inflight_reg};
    assign rd_en     = (state_reg == ST_RUN) && (occ_after < 2'd2);

    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = {frame_reg, col_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            frame_reg        <= '0;
            last_frame_reg   <= '0;
            col_reg          <= '0;
            c_reg            <= '0;
            g_reg            <= '0;
            cep_reg          <= '0;
            inflight_reg     <= 1'b0;
            inflight_vec_reg <= 1'b0;
            inflight_frm_reg <= 1'b0;
        end else begin
            // Last-word flags are decided at issue time and ride with the
            // returning data into the FIFO.
            inflight_reg     <= rd_en;
            inflight_vec_reg <= rd_en && last_c && last_g;
            inflight_frm_reg <= rd_en && last_c && last_g && last_f;

            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        cep_reg        <= cep_num;
                        last_frame_reg <= frame_num - EDGE_7 - 7'd1;
                        frame_reg      <= EDGE_7;
                        col_reg        <= '0;
                        c_reg          <= '0;
                        g_reg          <= '0;
                        state_reg      <= empty_range ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        if (last_c) begin
                            c_reg <= '0;
                            if (last_g) begin
                                g_reg   <= '0;
                                col_reg <= '0;
                                if (last_f) begin
                                    state_reg <= ST_DRAIN;
                                end else begin
                                    frame_reg <= frame_reg + 7'd1;
                                end
                            end else begin
                                // Skip the unused column between groups:
                                // next base is this base + cep_num + 1.
                                g_reg   <= g_reg + 2'd1;
                                col_reg <= col_reg + 7'd2;
                            end
                        end else begin
                            c_reg   <= c_reg + 7'd1;
                            col_reg <= col_reg + 7'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave as the final word is accepted so done follows
                    // it by exactly one cycle.
                    if (!inflight_reg && (fifo_empty || (!fifo_full && pop))) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    feature_skid_fifo #(
        .WIDTH(DATA_WIDTH + 2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_reg),
        .push_data({inflight_frm_reg, inflight_vec_reg, mem_rd_data}),
        .pop      (pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid      = !fifo_empty;
    assign out_data       = fifo_head[DATA_WIDTH-1:0];
    assign out_last_vec   = fifo_head[DATA_WIDTH] && out_valid;
    assign out_last_frame = fifo_head[DATA_WIDTH+1] && out_valid;
    assign busy           = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done           = (state_reg == ST_DONE);

endmodule
